// File: rtl/diaosi_types_pkg.sv
// Shared types for the cache/memory subsystem of the pipelined core.
// The arbiter enumerators carry an ARB_ prefix so they never clash with the
// cache controller state names that live alongside them.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DGNT = 2'd1,
    ARB_IGNT = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_STARVE_MAX_DEFAULT = 4;

  // Number of bits needed to hold a counter value in the range 0..max_val.
  function automatic int unsigned starve_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of dcache word completions granted while the icache is
// kept waiting. The sat flag looks ahead by one increment, so the arbiter
// can release a locked dcache burst on the very word that reaches the limit
// instead of letting one extra word through.
module arb_starve_cnt
  import diaosi_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned      CNT_W   = starve_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_MAX - 1);

  logic [CNT_W-1:0] starve;

  // Count starved completions, clear on icache service, hold at the limit.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve <= '0;
    end else if (clr) begin
      starve <= '0;
    end else if (inc && (starve != CNT_MAX)) begin
      starve <= starve + 1'b1;
    end
  end

  assign sat = (starve == CNT_MAX) || (inc && (starve == CNT_PRE));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Sequences the single-ported main RAM between the icache and dcache.
// The dcache normally wins, may hold the RAM across a two-word block with
// dlock, and is pre-empted once the icache has waited through STARVE_MAX
// dcache words. Data passes through untouched; only routing is decided here.
module cache_mem_arbiter
  import diaosi_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        dlock,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  arb_state_t state;
  arb_state_t state_next;

  logic d_req;
  logic d_done;
  logic i_done;
  logic starve_inc;
  logic starve_clr;
  logic starve_sat;

  assign d_req  = dREN | dWEN;
  assign d_done = (state == ARB_DGNT) && d_req && ramready;
  assign i_done = (state == ARB_IGNT) && iREN && ramready;

  // A dcache word only counts as starvation while the icache is waiting.
  assign starve_inc = d_done && iREN;
  assign starve_clr = i_done || !iREN;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  // Grant register; reset drops any grant in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection: dcache first unless the icache is starved, grants are
  // held until the word completes or the requester withdraws.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (d_req && !(starve_sat && iREN)) begin
          state_next = ARB_DGNT;
        end else if (iREN) begin
          state_next = ARB_IGNT;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_DGNT: begin
        if (!d_req) begin
          state_next = ARB_IDLE;
        end else if (!ramready) begin
          state_next = ARB_DGNT;
        end else if (dlock && !(starve_sat && iREN)) begin
          state_next = ARB_DGNT;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_IGNT: begin
        if (!iREN || ramready) begin
          state_next = ARB_IDLE;
        end else begin
          state_next = ARB_IGNT;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // RAM port steering and per-port completion signalling.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    case (state)
      ARB_DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      ARB_IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
    iwait = iREN & ~i_done;
    dwait = d_req & ~d_done;
    iload = i_done ? ramload : 32'h0;
    dload = d_done ? ramload : 32'h0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a word-level ownership model.
module tb_cache_mem_arbiter;

  localparam int MAX_STARVE = 4;
  localparam int OWN_NONE   = 0;
  localparam int OWN_DCACHE = 1;
  localparam int OWN_ICACHE = 2;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dlock;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int vectors;
  int miscompares;
  int m_owner;
  int m_starve;

  logic        s_iwait;
  logic        s_dwait;
  logic [31:0] s_iload;
  logic [31:0] s_dload;
  logic        s_ramREN;
  logic        s_ramWEN;
  logic [31:0] s_ramaddr;
  logic [31:0] s_ramstore;

  cache_mem_arbiter #(
    .STARVE_MAX(MAX_STARVE)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dlock   (dlock),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramready(ramready)
  );

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic i_ren, input logic [31:0] i_addr,
                               input logic d_ren, input logic d_wen,
                               input logic [31:0] d_addr, input logic [31:0] d_store,
                               input logic d_lock, input logic rdy,
                               input logic [31:0] r_load);
    iREN     = i_ren;
    iaddr    = i_addr;
    dREN     = d_ren;
    dWEN     = d_wen;
    daddr    = d_addr;
    dstore   = d_store;
    dlock    = d_lock;
    ramready = rdy;
    ramload  = r_load;
  endtask

  // Samples at the falling edge, compares with the model, then advances the
  // model across the next rising edge.
  task automatic checkOutput();
    bit          d_req;
    bit          d_done;
    bit          i_done;
    logic        e_ramREN;
    logic        e_ramWEN;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    int          next_owner;
    int          next_starve;
    @(negedge CLK);
    s_iwait    = iwait;
    s_dwait    = dwait;
    s_iload    = iload;
    s_dload    = dload;
    s_ramREN   = ramREN;
    s_ramWEN   = ramWEN;
    s_ramaddr  = ramaddr;
    s_ramstore = ramstore;

    d_req    = dREN || dWEN;
    d_done   = (m_owner == OWN_DCACHE) && d_req && ramready;
    i_done   = (m_owner == OWN_ICACHE) && iREN && ramready;
    e_ramWEN = (m_owner == OWN_DCACHE) && dWEN;
    e_ramREN = ((m_owner == OWN_DCACHE) && dREN && !dWEN) || ((m_owner == OWN_ICACHE) && iREN);
    e_addr   = (m_owner == OWN_DCACHE) ? daddr : (m_owner == OWN_ICACHE) ? iaddr : 32'h0;
    e_store  = (m_owner == OWN_DCACHE) ? dstore : 32'h0;

    checkVal("iwait", 32'(s_iwait), 32'(iREN && !i_done));
    checkVal("dwait", 32'(s_dwait), 32'(d_req && !d_done));
    checkVal("iload", s_iload, i_done ? ramload : 32'h0);
    checkVal("dload", s_dload, d_done ? ramload : 32'h0);
    checkVal("ramREN", 32'(s_ramREN), 32'(e_ramREN));
    checkVal("ramWEN", 32'(s_ramWEN), 32'(e_ramWEN));
    checkVal("ramaddr", s_ramaddr, e_addr);
    checkVal("ramstore", s_ramstore, e_store);

    next_owner  = m_owner;
    next_starve = m_starve;
    if (d_done) next_starve = iREN ? ((m_starve + 1 > MAX_STARVE) ? MAX_STARVE : m_starve + 1) : 0;
    if (i_done || !iREN) next_starve = 0;
    case (m_owner)
      OWN_NONE: begin
        if (d_req && !(m_starve == MAX_STARVE && iREN)) next_owner = OWN_DCACHE;
        else if (iREN) next_owner = OWN_ICACHE;
      end
      OWN_DCACHE: begin
        if (!d_req) next_owner = OWN_NONE;
        else if (d_done)
          next_owner = (dlock && !(iREN && next_starve == MAX_STARVE)) ? OWN_DCACHE : OWN_NONE;
      end
      default: begin
        if (!iREN || i_done) next_owner = OWN_NONE;
      end
    endcase
    if (!nRST) begin
      next_owner  = OWN_NONE;
      next_starve = 0;
    end
    @(posedge CLK);
    #1;
    m_owner  = next_owner;
    m_starve = next_starve;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < n; k++) checkOutput();
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int d_cnt;
    int first_i;
    int second_i;
    logic ren_hist[14];
    vectors     = 0;
    miscompares = 0;
    m_owner     = OWN_NONE;
    m_starve    = 0;

    // Reset held with both caches requesting.
    nRST = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    checkOutput();
    checkVal("rst_ramREN", 32'(s_ramREN), 32'h0);
    checkVal("rst_iwait", 32'(s_iwait), 32'h1);
    checkOutput();
    checkVal("rst_ramWEN", 32'(s_ramWEN), 32'h0);
    checkVal("rst_dwait", 32'(s_dwait), 32'h1);
    nRST = 1'b1;
    checkOutput();
    checkOutput();
    checkVal("rel_dgnt_addr", s_ramaddr, 32'h100);
    checkVal("rel_dgnt_ren", 32'(s_ramREN), 32'h1);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001);
    checkOutput();
    checkVal("rel_dload", s_dload, 32'hA5A5_0001);
    idleCycles(2);

    // Single icache read.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8C22_0004);
    checkOutput();
    checkVal("ird_wait_c0", 32'(s_iwait), 32'h1);
    checkOutput();
    checkVal("ird_wait_c1", 32'(s_iwait), 32'h0);
    checkVal("ird_iload", s_iload, 32'h8C22_0004);
    checkVal("ird_addr", s_ramaddr, 32'h40);
    idleCycles(2);

    // Contention: dcache first, icache after one idle cycle.
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
    checkOutput();
    checkOutput();
    checkVal("cont_dwait", 32'(s_dwait), 32'h0);
    checkVal("cont_iwait", 32'(s_iwait), 32'h1);
    checkVal("cont_daddr", s_ramaddr, 32'h100);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h3333_4444);
    checkOutput();
    checkVal("cont_bubble", 32'(s_ramREN), 32'h0);
    checkOutput();
    checkVal("cont_iwait2", 32'(s_iwait), 32'h0);
    checkVal("cont_iload", s_iload, 32'h3333_4444);
    idleCycles(2);

    // Locked two-word writeback.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0);
    checkOutput();
    checkOutput();
    checkVal("wb0_wen", 32'(s_ramWEN), 32'h1);
    checkVal("wb0_addr", s_ramaddr, 32'h200);
    checkVal("wb0_store", s_ramstore, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0);
    checkOutput();
    checkVal("wb1_wen", 32'(s_ramWEN), 32'h1);
    checkVal("wb1_addr", s_ramaddr, 32'h204);
    checkVal("wb1_store", s_ramstore, 32'hCAFE_F00D);
    checkVal("wb1_dwait", 32'(s_dwait), 32'h0);
    checkOutput();
    checkVal("wb_idle", 32'(s_ramWEN), 32'h0);
    idleCycles(2);

    // Starvation: locked dcache stream against a waiting icache.
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h5555_AAAA);
    d_cnt    = 0;
    first_i  = -1;
    second_i = -1;
    for (int c = 0; c < 14; c++) begin
      checkOutput();
      ren_hist[c] = s_ramREN;
      if (!s_dwait && first_i < 0) d_cnt++;
      if (!s_iwait) begin
        if (first_i < 0) first_i = c;
        else if (second_i < 0) second_i = c;
      end
    end
    checkVal("starve_dwords", 32'(d_cnt), 32'd4);
    checkVal("starve_bubble", 32'(ren_hist[5]), 32'h0);
    checkVal("starve_igrant", 32'(first_i), 32'd6);
    checkVal("starve_igrant2", 32'(second_i), 32'd13);
    idleCycles(2);

    // Withdrawal before ready, then a dual read/write request.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput();
    checkOutput();
    checkVal("wd_ren_gnt", 32'(s_ramREN), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput();
    checkVal("wd_ren_drop", 32'(s_ramREN), 32'h0);
    checkVal("wd_wen_drop", 32'(s_ramWEN), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
    checkOutput();
    checkVal("wd_idle", 32'(s_ramWEN), 32'h0);
    checkOutput();
    checkVal("dual_wen", 32'(s_ramWEN), 32'h1);
    checkVal("dual_ren", 32'(s_ramREN), 32'h0);
    idleCycles(2);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      nRST = ($urandom_range(0, 63) != 0);
      applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) == 0, $urandom, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom);
      checkOutput();
    end
    nRST = 1'b1;
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single-ported main RAM between the instruction cache and the data cache of the pipelined core. Data cache has priority. A starvation counter guarantees icache forward progress. A lock input lets the dcache hold the RAM for a two-word block fill or writeback. The block sits between the two cache controllers and the RAM model/bus, and is purely a sequencer: it never modifies data.

## Interface
- STARVE_MAX, 4: consecutive dcache word grants allowed while iREN is pending before the icache is forced in (≥1).
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; low = iload valid this cycle.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dlock  in  1  keep dcache grant after the current word completes (block transfer).
- dwait  out  1  dcache stall; low = access complete this cycle.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM completes the presented access this cycle.

## Operation
- States: ARB_IDLE, ARB_DGNT, ARB_IGNT.
- ARB_IDLE: RAM strobes 0, ramaddr/ramstore 0. Next state is chosen as follows:
  - If dREN|dWEN and not (starve==STARVE_MAX and iREN), go to ARB_DGNT.
  - Else if iREN, go to ARB_IGNT.
  - Else stay.
- ARB_DGNT: RAM is driven from the dcache port. ramWEN=dWEN. ramREN=dREN&~dWEN (write wins if both are set). ramaddr=daddr. ramstore=dstore.
  - On ramready: dwait=0, dload=ramload.
  - Next state is ARB_DGNT if dlock=1 and (dREN|dWEN), else ARB_IDLE.
- ARB_IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - On ramready: iwait=0, iload=ramload.
  - Next state is ARB_IDLE.
- Waits: iwait = iREN & ~(state==ARB_IGNT & ramready). dwait = (dREN|dWEN) & ~(state==ARB_DGNT & ramready).
  - iload/dload are 0 when the port is not completing.
- Withdrawal: if the granted requester drops its request before ramready, RAM strobes go to 0 in the same cycle and the state returns to ARB_IDLE next cycle. The starvation counter is unchanged.
- Starvation counter (starve, width clog2(STARVE_MAX+1)):
  - Increments on each dcache completion while iREN=1, saturating at STARVE_MAX.
  - Clears on an icache completion or whenever iREN=0.
- Forced icache grant under dlock: when starve==STARVE_MAX and iREN=1, dlock is ignored and the grant returns to ARB_IDLE after the current dcache word. The dcache sees dwait=1 until it is re-granted.

## Timing
- Reset (nRST low at an edge): state=ARB_IDLE and starve=0. Until the first post-reset edge the outputs follow the ARB_IDLE rules: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, waits = requests.
- Request to grant is 1 cycle (registered state). Minimum access is 2 cycles from request assertion: cycle 0 request seen in IDLE, cycle 1 grant + ramready gives wait low.
- Locked burst: the second word is presented in the cycle after the first completes, with no IDLE bubble.
- Unlocked back-to-back dcache accesses get one IDLE cycle between words.
- Simultaneous iREN and dREN in IDLE: dcache wins unless starve==STARVE_MAX.
- Reset asserted mid-access: the grant is dropped at that edge and strobes go low; the requester must re-present.

## Structure
- arb_state_t {ARB_IDLE, ARB_DGNT, ARB_IGNT}, logic [1:0], goes in diaosi_types_pkg. All enumerator names carry the ARB_ prefix so they do not collide with the existing cache-state enumerators.
- Sub-module arb_starve_cnt holds the saturating counter, parameterized by STARVE_MAX. Inputs are inc, clr, CLK, nRST; output is sat.
- The top level holds the FSM and the combinational RAM/port muxing.

## Test plan
- Reset: hold nRST=0 for 2 cycles with iREN=dREN=1 → ramREN=ramWEN=0, iwait=dwait=1. Release → ARB_DGNT next cycle with ramaddr=daddr.
- Single icache read: iREN=1, iaddr=0x40, RAM ready on first grant cycle with ramload=0x8C220004 → iwait low exactly 1 cycle, 2 cycles after request, with iload=0x8C220004.
- Contention: iREN=dREN=1, daddr=0x100, iaddr=0x0 → dcache served first, icache granted after one IDLE cycle.
- Locked writeback: dWEN=1, dlock=1, daddr 0x200 then 0x204, dstore 0xDEADBEEF then 0xCAFEF00D → two consecutive RAM writes with no gap, then IDLE.
- Starvation: STARVE_MAX=4, dREN held with dlock=1, iREN=1, RAM always ready → exactly 4 dcache completions, then an IDLE cycle, then ARB_IGNT; starve=0 after the icache completes.
- Withdrawal + dual strobe: drop dREN in ARB_DGNT before ramready → strobes 0 same cycle, IDLE next. Assert dREN=dWEN=1 → ramWEN=1, ramREN=0.
